// File: rtl/output_channel_tx_if.sv
// Byte-stream bundle for one router output channel: the show-ahead FIFO read
// side, the per-packet CRC configuration bit, the req/ack output byte link and
// the transmitter status flags.
interface output_channel_tx_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] fifo_rd_data;
   logic                  fifo_empty;
   logic                  fifo_rd_en;
   logic                  crc_en;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_out_req;
   logic                  data_out_ack;
   logic                  tx_busy;
   logic                  pkt_done;

   // Transmitter side: consumes FIFO and ack, produces the byte stream.
   modport master (
      input  fifo_rd_data,
      input  fifo_empty,
      input  crc_en,
      input  data_out_ack,
      output fifo_rd_en,
      output data_out,
      output data_out_req,
      output tx_busy,
      output pkt_done
   );

   // Environment side: FIFO owner and downstream receiver.
   modport slave (
      output fifo_rd_data,
      output fifo_empty,
      output crc_en,
      output data_out_ack,
      input  fifo_rd_en,
      input  data_out,
      input  data_out_req,
      input  tx_busy,
      input  pkt_done
   );
endinterface

// File: rtl/output_channel_tx.sv
// Per-channel packet transmitter. Pops a header and its payload from the
// channel FIFO, forwards them over a req/ack byte link, optionally appends a
// CRC-8 over everything sent, and leaves a req-low gap between packets so the
// receiver sees a fresh req rising edge at each packet start.
module output_channel_tx #(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    DATA_SIZE  = 6,
   parameter logic [DATA_WIDTH-1:0] CRC_POLY   = 8'h07
) (
   input logic                  clk,
   input logic                  rst_n,
   output_channel_tx_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_CRC,
      S_GAP
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_SIZE-1:0]  rem_q, rem_d;
   logic [DATA_WIDTH-1:0] crc_q, crc_d;
   logic                  crc_en_l_q, crc_en_l_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  req_q, req_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  rd_en_c;
   logic                  slot_free;

   // One full byte of MSB-first CRC-8 (no reflection, no final XOR).
   function automatic logic [DATA_WIDTH-1:0] crc_step(
      input logic [DATA_WIDTH-1:0] crc_in,
      input logic [DATA_WIDTH-1:0] byte_in
   );
      logic [DATA_WIDTH-1:0] c;
      c = crc_in ^ byte_in;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (c[DATA_WIDTH-1]) c = (c << 1) ^ CRC_POLY;
         else                 c = c << 1;
      end
      return c;
   endfunction

   // The output register may take a new byte when it is empty or being accepted now.
   assign slot_free = !req_q || bus.data_out_ack;

   // Next-state, pop strobe and output-register updates for the framing FSM.
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      crc_d      = crc_q;
      crc_en_l_d = crc_en_l_q;
      data_d     = data_q;
      req_d      = req_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      rd_en_c    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!bus.fifo_empty) begin
               rd_en_c    = 1'b1;
               data_d     = bus.fifo_rd_data;
               req_d      = 1'b1;
               rem_d      = bus.fifo_rd_data[DATA_SIZE-1:0];
               crc_en_l_d = bus.crc_en;
               crc_d      = crc_step('0, bus.fifo_rd_data);
               busy_d     = 1'b1;
               state_d    = S_HDR;
            end
         end

         S_HDR, S_DATA: begin
            if (slot_free) begin
               if (rem_q != '0) begin
                  if (!bus.fifo_empty) begin
                     rd_en_c = 1'b1;
                     data_d  = bus.fifo_rd_data;
                     rem_d   = rem_q - DATA_SIZE'(1);
                     crc_d   = crc_step(crc_q, bus.fifo_rd_data);
                     req_d   = 1'b1;
                     state_d = S_DATA;
                  end else begin
                     // Underrun: drop req and wait in place for the next payload byte.
                     req_d = 1'b0;
                  end
               end else if (crc_en_l_q) begin
                  data_d  = crc_q;
                  req_d   = 1'b1;
                  state_d = S_CRC;
               end else begin
                  req_d   = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_GAP;
               end
            end
         end

         S_CRC: begin
            if (req_q && bus.data_out_ack) begin
               req_d   = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_GAP;
            end
         end

         S_GAP: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, counters, CRC and the registered output byte link.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rem_q      <= '0;
         crc_q      <= '0;
         crc_en_l_q <= 1'b0;
         data_q     <= '0;
         req_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         crc_q      <= crc_d;
         crc_en_l_q <= crc_en_l_d;
         data_q     <= data_d;
         req_q      <= req_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // The pop strobe is combinational, so it is gated off while reset is held.
   assign bus.fifo_rd_en   = rd_en_c & rst_n;
   assign bus.data_out     = data_q;
   assign bus.data_out_req = req_q;
   assign bus.tx_busy      = busy_q;
   assign bus.pkt_done     = done_q;

endmodule
